// File: rtl/sram_host_pkg.sv
// Shared types and constants for the serial SRAM controller host bridge.
package sram_host_pkg;

  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned ADDR_WIDTH  = 10;
  localparam int unsigned FRAME_WIDTH = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [1:0] CTRL_MODE_LOAD  = 2'b00;
  localparam logic [1:0] CTRL_MODE_READ  = 2'b01;
  localparam logic [1:0] CTRL_MODE_WRITE = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_SETUP,
    S_LD_ARM,
    S_LD_GAP,
    S_LD_SHIFT,
    S_LD_WRDY,
    S_LD_REL1,
    S_LD_REL2,
    S_LD_WIDLE,
    S_XF_SETUP,
    S_XF_ARM,
    S_XF_WRDY,
    S_XF_REL1,
    S_XF_REL2,
    S_XF_WIDLE,
    S_DONE
  } state_e;

endpackage

// File: rtl/sram_ctrl_frame_shifter.sv
// Frame serializer toward CTRL_SI (LSB first) and byte deserializer from CTRL_SO.
module sram_ctrl_frame_shifter
  import sram_host_pkg::*;
#(
  parameter int unsigned FRAME_W = FRAME_WIDTH,
  parameter int unsigned BYTE_W  = DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               shift,
  input  logic [FRAME_W-1:0] frame,
  input  logic               so,
  output logic               si,
  output logic [BYTE_W-1:0]  so_byte,
  output logic               done_c
);

  localparam int unsigned BIT_W = $clog2(BYTE_W);

  logic [FRAME_W-1:0] sr;
  logic [4:0]         cnt;

  assign done_c = shift && (cnt == 5'(FRAME_W - 1));

  // si always shows the bit of the current shift cycle; returns low after the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      cnt     <= '0;
      si      <= 1'b0;
      so_byte <= '0;
    end else if (start) begin
      sr      <= frame >> 1;
      si      <= frame[0];
      cnt     <= '0;
      so_byte <= '0;
    end else if (shift) begin
      if (cnt < 5'(BYTE_W)) so_byte[cnt[BIT_W-1:0]] <= so;
      if (done_c) begin
        si  <= 1'b0;
        cnt <= '0;
      end else begin
        si  <= sr[0];
        sr  <= sr >> 1;
        cnt <= cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/sram_ctrl_host_bridge.sv
// Host-side master turning byte/word requests into SRAM controller load/xfer/flush sequences.
// Optional wait-state timeout abort: define SRAM_HOST_BRIDGE_TIMEOUT_EN.
module sram_ctrl_host_bridge
  import sram_host_pkg::*;
#(
  parameter int unsigned MEMORY_DATA_WIDTH = 8,
  parameter int unsigned MEMORY_ADDR_WIDTH = 10,
  parameter int unsigned TIMEOUT_CYCLES    = 4096
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           REQ_VALID,
  output logic                           REQ_READY,
  input  logic                           REQ_WR,
  input  logic                           REQ_WORD,
  input  logic [MEMORY_ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [2*MEMORY_DATA_WIDTH-1:0] REQ_WDATA,
  output logic                           RSP_VALID,
  output logic [2*MEMORY_DATA_WIDTH-1:0] RSP_RDATA,
  output logic                           RSP_ERR,
  output logic                           BUSY,
  output logic                           CTRL_BGN,
  output logic [1:0]                     CTRL_MODE,
  output logic                           LOAD_N,
  output logic                           CTRL_SI,
  input  logic                           CTRL_RDY,
  input  logic                           CTRL_SO
);

  localparam int unsigned DW = MEMORY_DATA_WIDTH;
  localparam int unsigned AW = MEMORY_ADDR_WIDTH;
  localparam int unsigned WW = 2 * MEMORY_DATA_WIDTH;
  localparam int unsigned FW = AW + DW;

  state_e        state_q, state_d;
  logic          flush_q, flush_d;
  logic          byte_q, byte_d;
  logic          wr_q, word_q;
  logic [AW-1:0] addr_q;
  logic [WW-1:0] wdata_q;
  logic [WW-1:0] rd_acc_q, rd_acc_d;
  logic          bgn_q, bgn_d, load_n_q, load_n_d;
  logic [1:0]    mode_q, mode_d;
  logic          ready_q, valid_q, err_q, busy_q;
  logic [WW-1:0] rdata_q;

  logic          accept_c, abort_c, sh_done_c;
  logic [AW-1:0] cur_addr_c;
  logic [DW-1:0] cur_data_c, so_byte;
  logic [FW-1:0] frame_c;

  assign accept_c = (state_q == S_IDLE) && REQ_VALID && ready_q;

  // Word ops send the odd (high) byte first; flush frames are all zero
  assign cur_addr_c = word_q ? {addr_q[AW-1:1], ~byte_q} : addr_q;
  assign cur_data_c = !wr_q ? '0 : (word_q && !byte_q) ? wdata_q[WW-1:DW] : wdata_q[DW-1:0];
  assign frame_c    = flush_q ? '0 : {cur_addr_c, cur_data_c};

`ifdef SRAM_HOST_BRIDGE_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        wait_c, wait_ok_c;

  assign wait_c    = (state_q == S_LD_WRDY) || (state_q == S_LD_WIDLE) ||
                     (state_q == S_XF_WRDY) || (state_q == S_XF_WIDLE);
  assign wait_ok_c = ((state_q == S_LD_WRDY) || (state_q == S_XF_WRDY)) ? CTRL_RDY : !CTRL_RDY;
  assign abort_c   = wait_c && !wait_ok_c && (tmo_q >= 16'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK) begin
    if (RST || (state_d != state_q)) tmo_q <= '0;
    else if (wait_c)                 tmo_q <= tmo_q + 16'd1;
  end
`else
  assign abort_c = 1'b0;
`endif

  sram_ctrl_frame_shifter #(
    .FRAME_W (FW),
    .BYTE_W  (DW)
  ) u_shifter (
    .clk     (CLK),
    .rst     (RST),
    .start   (state_q == S_LD_GAP),
    .shift   (state_q == S_LD_SHIFT),
    .frame   (frame_c),
    .so      (CTRL_SO),
    .si      (CTRL_SI),
    .so_byte (so_byte),
    .done_c  (sh_done_c)
  );

  // Next state, then next controller drive from the state being entered
  always_comb begin
    state_d  = state_q;
    flush_d  = flush_q;
    byte_d   = byte_q;
    rd_acc_d = rd_acc_q;
    bgn_d    = bgn_q;
    mode_d   = mode_q;
    load_n_d = load_n_q;

    case (state_q)
      S_IDLE: if (accept_c) begin
        state_d  = S_LD_SETUP;
        flush_d  = 1'b0;
        byte_d   = 1'b0;
        rd_acc_d = '0;
      end
      S_LD_SETUP: state_d = S_LD_ARM;
      S_LD_ARM:   state_d = S_LD_GAP;
      S_LD_GAP:   state_d = S_LD_SHIFT;
      S_LD_SHIFT: if (sh_done_c) state_d = S_LD_WRDY;
      S_LD_WRDY:  if (CTRL_RDY) state_d = S_LD_REL1;
      S_LD_REL1:  state_d = S_LD_REL2;
      S_LD_REL2:  state_d = S_LD_WIDLE;
      S_LD_WIDLE: if (!CTRL_RDY) begin
        if (!flush_q) begin
          state_d = S_XF_SETUP;
        end else begin
          if (word_q && !byte_q) rd_acc_d[WW-1:DW] = so_byte;
          else                   rd_acc_d[DW-1:0]  = so_byte;
          if (word_q && !byte_q) begin
            state_d = S_LD_SETUP;
            byte_d  = 1'b1;
            flush_d = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_XF_SETUP: state_d = S_XF_ARM;
      S_XF_ARM:   state_d = S_XF_WRDY;
      S_XF_WRDY:  if (CTRL_RDY) state_d = S_XF_REL1;
      S_XF_REL1:  state_d = S_XF_REL2;
      S_XF_REL2:  state_d = S_XF_WIDLE;
      S_XF_WIDLE: if (!CTRL_RDY) begin
        if (!wr_q) begin
          state_d = S_LD_SETUP;
          flush_d = 1'b1;
        end else if (word_q && !byte_q) begin
          state_d = S_LD_SETUP;
          byte_d  = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_c) state_d = S_DONE;

    case (state_d)
      S_LD_SETUP: begin
        bgn_d  = 1'b1;
        mode_d = CTRL_MODE_LOAD;
      end
      S_XF_SETUP: begin
        bgn_d  = 1'b1;
        mode_d = wr_q ? CTRL_MODE_WRITE : CTRL_MODE_READ;
      end
      S_LD_ARM, S_XF_ARM:   load_n_d = 1'b0;
      S_LD_REL1, S_XF_REL1: bgn_d    = 1'b0;
      S_LD_REL2, S_XF_REL2: load_n_d = 1'b1;
      default: ;
    endcase

    if (abort_c) begin
      bgn_d    = 1'b0;
      load_n_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      flush_q  <= 1'b0;
      byte_q   <= 1'b0;
      wr_q     <= 1'b0;
      word_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_acc_q <= '0;
      bgn_q    <= 1'b0;
      mode_q   <= CTRL_MODE_LOAD;
      load_n_q <= 1'b1;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      byte_q   <= byte_d;
      rd_acc_q <= rd_acc_d;
      bgn_q    <= bgn_d;
      mode_q   <= mode_d;
      load_n_q <= load_n_d;
      ready_q  <= (state_d == S_IDLE);
      busy_q   <= (state_d != S_IDLE);
      valid_q  <= (state_d == S_DONE);
      err_q    <= abort_c;
      if ((state_d == S_DONE) && !abort_c && !wr_q) rdata_q <= rd_acc_d;
      if (accept_c) begin
        wr_q    <= REQ_WR;
        word_q  <= REQ_WORD;
        addr_q  <= REQ_ADDR;
        wdata_q <= REQ_WDATA;
      end
    end
  end

  assign REQ_READY = ready_q;
  assign RSP_VALID = valid_q;
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;
  assign BUSY      = busy_q;
  assign CTRL_BGN  = bgn_q;
  assign CTRL_MODE = mode_q;
  assign LOAD_N    = load_n_q;

endmodule

// File: tb/tb_sram_ctrl_host_bridge.sv
// Directed bench for sram_ctrl_host_bridge against a zero-delay SRAM controller model.
module tb_sram_ctrl_host_bridge;

  logic        CLK, RST;
  logic        REQ_VALID, REQ_READY, REQ_WR, REQ_WORD;
  logic [9:0]  REQ_ADDR;
  logic [15:0] REQ_WDATA;
  logic        RSP_VALID, RSP_ERR, BUSY;
  logic [15:0] RSP_RDATA;
  logic        CTRL_BGN, LOAD_N, CTRL_SI, CTRL_RDY, CTRL_SO;
  logic [1:0]  CTRL_MODE;

  sram_ctrl_host_bridge #(
    .MEMORY_DATA_WIDTH (8),
    .MEMORY_ADDR_WIDTH (10),
    .TIMEOUT_CYCLES    (16)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WR    (REQ_WR),
    .REQ_WORD  (REQ_WORD),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERR   (RSP_ERR),
    .BUSY      (BUSY),
    .CTRL_BGN  (CTRL_BGN),
    .CTRL_MODE (CTRL_MODE),
    .LOAD_N    (LOAD_N),
    .CTRL_SI   (CTRL_SI),
    .CTRL_RDY  (CTRL_RDY),
    .CTRL_SO   (CTRL_SO)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Controller model: 2 idle cycles after LOAD_N falls, then 18 frame bits LSB first
  logic [7:0]  mem [1024];
  int          m_cnt    = 0;
  logic [17:0] m_frame  = '0;
  logic        m_xf     = 1'b0;
  logic        m_logged = 1'b0;
  logic [7:0]  m_rbyte  = '0;
  logic [17:0] frames [$];
  logic [1:0]  modes [$];
  logic        stuck0, pre_we;
  logic [9:0]  pre_addr;
  logic [7:0]  pre_data;

  always @(posedge CLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (CTRL_BGN && !LOAD_N) begin
      if (CTRL_MODE == 2'b00) begin
        if (m_cnt >= 2 && m_cnt < 20) m_frame[m_cnt-2] <= CTRL_SI;
        if (m_cnt < 20) m_cnt <= m_cnt + 1;
        else if (!m_logged) begin
          frames.push_back(m_frame);
          m_logged <= 1'b1;
        end
      end else if (!m_xf) begin
        m_xf <= 1'b1;
        modes.push_back(CTRL_MODE);
        if (CTRL_MODE == 2'b11) mem[m_frame[17:8]] <= m_frame[7:0];
        else                    m_rbyte <= mem[m_frame[17:8]];
      end
    end else if (!CTRL_BGN) begin
      m_cnt    <= 0;
      m_xf     <= 1'b0;
      m_logged <= 1'b0;
    end
  end

  always_comb begin
    CTRL_SO = 1'b0;
    if (m_cnt >= 2 && m_cnt < 10) CTRL_SO = m_rbyte[m_cnt-2];
  end

  assign CTRL_RDY = !stuck0 && CTRL_BGN && !LOAD_N && (CTRL_MODE != 2'b00 || m_cnt >= 20);

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    @(negedge CLK);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge CLK);
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic wr, input logic word, input logic [9:0] a, input logic [15:0] d);
    @(negedge CLK);
    for (int i = 0; i < 20 && !REQ_READY; i++) @(negedge CLK);
    REQ_VALID = 1'b1; REQ_WR = wr; REQ_WORD = word; REQ_ADDR = a; REQ_WDATA = d;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
  endtask

  task automatic wait_rsp(input int pulse_at, output int lat, output logic [15:0] rd, output logic er);
    lat = -1; rd = '0; er = 1'b0;
    for (int c = 1; c <= 400 && lat < 0; c++) begin
      if (c == pulse_at) begin
        REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_WORD = 1'b0; REQ_ADDR = 10'h3FF; REQ_WDATA = 16'h0011;
      end
      @(posedge CLK);
      #1 REQ_VALID = 1'b0;
      if (RSP_VALID) begin
        lat = c; rd = RSP_RDATA; er = RSP_ERR;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of stimulus, expected finish");
    $fatal(1);
  end

  initial begin
    int          lat, fb, mb, nv;
    logic [15:0] rd;
    logic        er;

    RST = 1'b1; REQ_VALID = 1'b0; REQ_WR = 1'b0; REQ_WORD = 1'b0;
    REQ_ADDR = '0; REQ_WDATA = '0; stuck0 = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    chk("reset_ctrl", 32'({CTRL_BGN, CTRL_MODE, LOAD_N, CTRL_SI, REQ_READY, RSP_VALID, RSP_ERR, BUSY}), 32'h028);
    chk("reset_rdata", 32'(RSP_RDATA), 32'h0);

    preload(10'h3FF, 8'hA5); preload(10'h004, 8'h58); preload(10'h005, 8'h00);
    preload(10'h006, 8'h71); preload(10'h007, 8'h01); preload(10'h100, 8'h00);

    // byte write 0x3C @ 0x021
    fb = frames.size(); mb = modes.size();
    issue(1'b1, 1'b0, 10'h021, 16'h003C);
    chk("t1_accept_ready_busy", 32'({REQ_READY, BUSY}), 32'h1);
    wait_rsp(0, lat, rd, er);
    chk("t1_latency", 32'(lat), 32'd31);
    chk("t1_err", 32'(er), 32'h0);
    chk("t1_nframes", 32'(frames.size() - fb), 32'd1);
    chk("t1_frame", 32'(frames[fb]), 32'h0213C);
    chk("t1_mode", 32'(modes[mb]), 32'h3);
    @(posedge CLK); #1;
    chk("t1_after_done", 32'({REQ_READY, BUSY, RSP_VALID}), 32'h4);

    // word write 0x3C00 @ 0x000: odd byte first
    fb = frames.size(); mb = modes.size();
    issue(1'b1, 1'b1, 10'h000, 16'h3C00);
    wait_rsp(0, lat, rd, er);
    chk("t2_latency", 32'(lat), 32'd62);
    chk("t2_err", 32'(er), 32'h0);
    chk("t2_frame_hi", 32'(frames[fb]), 32'h0013C);
    chk("t2_frame_lo", 32'(frames[fb+1]), 32'h00000);
    chk("t2_modes", 32'({modes[mb], modes[mb+1]}), 32'hF);

    // word write at odd address: bit 0 ignored
    fb = frames.size();
    issue(1'b1, 1'b1, 10'h00B, 16'hBEEF);
    wait_rsp(0, lat, rd, er);
    chk("t2b_frame_hi", 32'(frames[fb]), 32'h00BBE);
    chk("t2b_frame_lo", 32'(frames[fb+1]), 32'h00AEF);

    // word read @ 0x004
    fb = frames.size(); mb = modes.size();
    issue(1'b0, 1'b1, 10'h004, 16'hFFFF);
    wait_rsp(0, lat, rd, er);
    chk("t3_latency", 32'(lat), 32'd112);
    chk("t3_rdata", 32'(rd), 32'h0058);
    chk("t3_mode", 32'(modes[mb]), 32'h1);
    chk("t3_frame_hi", 32'(frames[fb]), 32'h00500);
    chk("t3_frame_lo", 32'(frames[fb+2]), 32'h00400);
    @(posedge CLK); #1;
    chk("t3_rdata_hold", 32'(RSP_RDATA), 32'h0058);

    // word read @ 0x006 with an ignored mid-op request
    issue(1'b0, 1'b1, 10'h006, 16'h0000);
    wait_rsp(40, lat, rd, er);
    chk("t4_latency", 32'(lat), 32'd112);
    chk("t4_rdata", 32'(rd), 32'h0171);
    nv = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge CLK); #1;
      if (RSP_VALID) nv++;
    end
    chk("t4_no_extra_rsp", 32'(nv), 32'd0);
    chk("t4_mem_untouched", 32'(mem[10'h3FF]), 32'hA5);

    // byte read returns zero-extended byte
    issue(1'b0, 1'b0, 10'h021, 16'h0000);
    wait_rsp(0, lat, rd, er);
    chk("t5_latency", 32'(lat), 32'd56);
    chk("t5_rdata", 32'(rd), 32'h003C);

`ifdef SRAM_HOST_BRIDGE_TIMEOUT_EN
    // stuck CTRL_RDY: abort 17 cycles after entering LD_WRDY
    stuck0 = 1'b1;
    issue(1'b0, 1'b0, 10'h004, 16'h0000);
    wait_rsp(0, lat, rd, er);
    chk("tmo_latency", 32'(lat), 32'd38);
    chk("tmo_err", 32'(er), 32'h1);
    chk("tmo_rdata_kept", 32'(rd), 32'h003C);
    chk("tmo_ctrl_idle", 32'({CTRL_BGN, LOAD_N}), 32'h1);
    stuck0 = 1'b0;
    @(posedge CLK); #1;
    chk("tmo_err_pulse", 32'({RSP_VALID, RSP_ERR}), 32'h0);
`endif

    // reset during shift cycle 9 of a byte write
    issue(1'b1, 1'b0, 10'h100, 16'h00FF);
    repeat (12) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    chk("rst_mid_ctrl", 32'({CTRL_BGN, CTRL_MODE, LOAD_N, CTRL_SI, REQ_READY, RSP_VALID, RSP_ERR, BUSY}), 32'h028);
    chk("rst_mid_rdata", 32'(RSP_RDATA), 32'h0);
    RST = 1'b0;
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK); #1;
      if (RSP_VALID) nv++;
    end
    chk("rst_mid_no_rsp", 32'(nv), 32'd0);
    chk("rst_mid_ready", 32'(REQ_READY), 32'h1);

    issue(1'b0, 1'b0, 10'h100, 16'h0000);
    wait_rsp(0, lat, rd, er);
    chk("rst_recover_latency", 32'(lat), 32'd56);
    chk("rst_recover_rdata", 32'(rd), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
